// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : Transmit-side scheduler for the shared UART TX line. Picks one
//            of two byte requesters round-robin, frames the byte as start,
//            data (LSB first), optional parity and stop bits, and paces every
//            bit at CLK_DIV clock cycles.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    output logic       s1_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output logic       last_src
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (CLK_DIV < 2) begin : g_chk_clk_div
        $error("uart_tx_sched: CLK_DIV must be 2 or more");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_chk_data_bits
        $error("uart_tx_sched: DATA_BITS must be in the range 5 to 8");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_chk_stop_bits
        $error("uart_tx_sched: STOP_BITS must be 1 or 2");
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              c_BAUD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam [c_BAUD_W-1:0]   c_BAUD_LAST = c_BAUD_W'(CLK_DIV - 1);
    localparam [c_BAUD_W-1:0]   c_BAUD_ONE  = c_BAUD_W'(1);
    localparam [3:0]            c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam [3:0]            c_STOP_LAST = 4'(STOP_BITS - 1);

    localparam [2:0] c_ST_IDLE   = 3'd0;
    localparam [2:0] c_ST_START  = 3'd1;
    localparam [2:0] c_ST_DATA   = 3'd2;
    localparam [2:0] c_ST_PARITY = 3'd3;
    localparam [2:0] c_ST_STOP   = 3'd4;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [c_BAUD_W-1:0] r_baud;
    logic [3:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_parity;
    logic                r_tx;
    logic                r_last_src;
    logic                r_prio;      // 0 favours port 0, 1 favours port 1

    logic                w_idle;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_accept;
    logic                w_baud_last;
    logic [7:0]          w_sel_data;
    logic                w_sel_parity;

    // Round-robin grant: a port wins if it is the only one asking or if the
    // pointer favours it. Only state, valids and pointer feed the decision.
    always_comb begin
        w_idle   = (r_state == c_ST_IDLE);
        w_grant0 = w_idle && s0_valid && (!s1_valid || !r_prio);
        w_grant1 = w_idle && s1_valid && (!s0_valid ||  r_prio);
        w_accept = w_grant0 || w_grant1;
    end

    // Select the granted byte and precompute its parity over the sent bits only
    always_comb begin
        w_sel_data   = w_grant1 ? s1_data : s0_data;
        w_sel_parity = (PARITY_ODD != 0);
        for (int i = 0; i < DATA_BITS; i++) begin
            w_sel_parity = w_sel_parity ^ w_sel_data[i];
        end
    end

    assign w_baud_last = (r_baud == c_BAUD_LAST);

    // Frame sequencer: tx is loaded with the value of the next state's bit on
    // the same edge the state advances, so the line never glitches.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= c_ST_IDLE;
            r_baud     <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_last_src <= 1'b0;
            r_prio     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_accept) begin
                        r_state    <= c_ST_START;
                        r_baud     <= '0;
                        r_bit_cnt  <= '0;
                        r_shift    <= w_sel_data;
                        r_parity   <= w_sel_parity;
                        r_last_src <= w_grant1;
                        // Favour the port that just lost (or did not ask)
                        r_prio     <= w_grant0;
                        r_tx       <= 1'b0;
                    end
                end

                c_ST_START: begin
                    if (w_baud_last) begin
                        r_state   <= c_ST_DATA;
                        r_baud    <= '0;
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end

                c_ST_DATA: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit_cnt == c_DATA_LAST) begin
                            r_bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                r_state <= c_ST_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= c_ST_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end

                c_ST_PARITY: begin
                    if (w_baud_last) begin
                        r_state   <= c_ST_STOP;
                        r_baud    <= '0;
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b1;
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end

                c_ST_STOP: begin
                    r_tx <= 1'b1;
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit_cnt == c_STOP_LAST) begin
                            r_state   <= c_ST_IDLE;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign s0_ready = w_grant0;
    assign s1_ready = w_grant1;
    assign tx       = r_tx;
    assign busy     = !w_idle;
    assign tx_done  = (r_state == c_ST_STOP) && w_baud_last && (r_bit_cnt == c_STOP_LAST);
    assign last_src = r_last_src;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Purpose  : Directed self-checking bench for uart_tx_sched. Four instances
//            cover 8N1, 8E1, 8O1 and 5N2 framing at CLK_DIV=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 8N1 instance
    logic       a_v0 = 1'b0, a_v1 = 1'b0;
    logic [7:0] a_d0 = 8'h00, a_d1 = 8'h00;
    logic       a_r0, a_r1, a_tx, a_busy, a_done, a_last;
    // 8E1 / 8O1 instances share stimulus
    logic       p_v = 1'b0;
    logic [7:0] p_d = 8'h00;
    logic       pe_r0, pe_r1, pe_tx, pe_busy, pe_done, pe_last;
    logic       po_r0, po_r1, po_tx, po_busy, po_done, po_last;
    // 5N2 instance
    logic       f_v = 1'b0;
    logic [7:0] f_d = 8'h00;
    logic       f_r0, f_r1, f_tx, f_busy, f_done, f_last;

    uart_tx_sched #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
        .clk(clk), .reset_n(reset_n),
        .s0_valid(a_v0), .s0_data(a_d0), .s0_ready(a_r0),
        .s1_valid(a_v1), .s1_data(a_d1), .s1_ready(a_r1),
        .tx(a_tx), .busy(a_busy), .tx_done(a_done), .last_src(a_last));

    uart_tx_sched #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_pe (
        .clk(clk), .reset_n(reset_n),
        .s0_valid(p_v), .s0_data(p_d), .s0_ready(pe_r0),
        .s1_valid(1'b0), .s1_data(8'h00), .s1_ready(pe_r1),
        .tx(pe_tx), .busy(pe_busy), .tx_done(pe_done), .last_src(pe_last));

    uart_tx_sched #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_po (
        .clk(clk), .reset_n(reset_n),
        .s0_valid(p_v), .s0_data(p_d), .s0_ready(po_r0),
        .s1_valid(1'b0), .s1_data(8'h00), .s1_ready(po_r1),
        .tx(po_tx), .busy(po_busy), .tx_done(po_done), .last_src(po_last));

    uart_tx_sched #(.CLK_DIV(4), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_f (
        .clk(clk), .reset_n(reset_n),
        .s0_valid(f_v), .s0_data(f_d), .s0_ready(f_r0),
        .s1_valid(1'b0), .s1_data(8'h00), .s1_ready(f_r1),
        .tx(f_tx), .busy(f_busy), .tx_done(f_done), .last_src(f_last));

    // Hard stop in case anything stalls the sequence
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++; if (a_tx !== 1'b1)   begin n_fail++; $display("FAIL reset_tx: got %b want 1", a_tx); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", a_done); end
        n_checks++; if (a_last !== 1'b0) begin n_fail++; $display("FAIL reset_last_src: got %b want 0", a_last); end
        n_checks++; if (a_r0 !== 1'b0 || a_r1 !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b%b want 00", a_r0, a_r1); end
        reset_n = 1'b1;
        tick();
    endtask

    // 0xA5 8N1: periods 0,1,0,1,0,0,1,0,1,1 (index 0 = start bit)
    task automatic test_single_frame();
        logic [9:0] exp_seq;
        exp_seq = 10'b11_0100_1010;
        a_d0 = 8'hA5;
        a_v0 = 1'b1;
        #1;
        n_checks++; if (a_r0 !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", a_r0); end
        tick();
        a_v0 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            n_checks++; if (a_tx !== exp_seq[(k-1)/4]) begin n_fail++; $display("FAIL single_tx cyc %0d: got %b want %b", k, a_tx, exp_seq[(k-1)/4]); end
            n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy cyc %0d: got %b want 1", k, a_busy); end
            n_checks++; if (a_done !== (k == 40)) begin n_fail++; $display("FAIL single_done cyc %0d: got %b want %b", k, a_done, (k == 40)); end
            tick();
        end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", a_busy); end
        n_checks++; if (a_tx !== 1'b1)   begin n_fail++; $display("FAIL single_tx_idle: got %b want 1", a_tx); end
        n_checks++; if (a_last !== 1'b0) begin n_fail++; $display("FAIL single_last_src: got %b want 0", a_last); end
    endtask

    // 0x07: even parity bit 1, odd parity bit 0, 11 periods = 44 cycles
    task automatic test_parity();
        logic [10:0] exp_e;
        logic [10:0] exp_o;
        exp_e = 11'b110_0000_1110;
        exp_o = 11'b100_0000_1110;
        p_d = 8'h07;
        p_v = 1'b1;
        #1;
        n_checks++; if (pe_r0 !== 1'b1 || po_r0 !== 1'b1) begin n_fail++; $display("FAIL parity_ready: got %b%b want 11", pe_r0, po_r0); end
        tick();
        p_v = 1'b0;
        for (int k = 1; k <= 44; k++) begin
            n_checks++; if (pe_tx !== exp_e[(k-1)/4]) begin n_fail++; $display("FAIL parity_even_tx cyc %0d: got %b want %b", k, pe_tx, exp_e[(k-1)/4]); end
            n_checks++; if (po_tx !== exp_o[(k-1)/4]) begin n_fail++; $display("FAIL parity_odd_tx cyc %0d: got %b want %b", k, po_tx, exp_o[(k-1)/4]); end
            n_checks++; if (pe_busy !== 1'b1) begin n_fail++; $display("FAIL parity_busy cyc %0d: got %b want 1", k, pe_busy); end
            n_checks++; if (pe_done !== (k == 44)) begin n_fail++; $display("FAIL parity_done cyc %0d: got %b want %b", k, pe_done, (k == 44)); end
            tick();
        end
        n_checks++; if (pe_busy !== 1'b0 || po_busy !== 1'b0) begin n_fail++; $display("FAIL parity_busy_end: got %b%b want 00", pe_busy, po_busy); end
    endtask

    // 5N2 with 0x1F: start then 5 ones then 2 stop periods, 32 cycles
    task automatic test_stop2_5bit();
        f_d = 8'h1F;
        f_v = 1'b1;
        #1;
        n_checks++; if (f_r0 !== 1'b1) begin n_fail++; $display("FAIL stop2_ready: got %b want 1", f_r0); end
        tick();
        f_v = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            n_checks++; if (f_tx !== (k > 4)) begin n_fail++; $display("FAIL stop2_tx cyc %0d: got %b want %b", k, f_tx, (k > 4)); end
            n_checks++; if (f_busy !== 1'b1) begin n_fail++; $display("FAIL stop2_busy cyc %0d: got %b want 1", k, f_busy); end
            n_checks++; if (f_done !== (k == 32)) begin n_fail++; $display("FAIL stop2_done cyc %0d: got %b want %b", k, f_done, (k == 32)); end
            tick();
        end
        n_checks++; if (f_busy !== 1'b0) begin n_fail++; $display("FAIL stop2_busy_end: got %b want 0", f_busy); end
    endtask

    // Both valid from reset: grants s0 @0, s1 @41, s0 @82
    task automatic test_contention();
        logic       exp_src [3];
        int         exp_cyc [3];
        logic [7:0] exp_dat [3];
        logic [7:0] cap;
        int         g;
        int         gcyc;
        int         since;
        exp_src = '{1'b0, 1'b1, 1'b0};
        exp_cyc = '{0, 41, 82};
        exp_dat = '{8'h11, 8'h22, 8'h11};
        cap  = 8'h00;
        g    = 0;
        gcyc = 0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        a_d0 = 8'h11;
        a_d1 = 8'h22;
        a_v0 = 1'b1;
        a_v1 = 1'b1;
        #1;
        for (int c = 0; c < 122; c++) begin
            n_checks++; if (a_r0 && a_r1) begin n_fail++; $display("FAIL cont_both_ready cyc %0d: got 11 want one-hot", c); end
            if (g > 0) begin
                since = c - gcyc;
                if (since >= 6 && since <= 34 && ((since - 2) % 4) == 0) cap[(since - 2) / 4 - 1] = a_tx;
                if (since == 1) begin
                    n_checks++; if (a_last !== exp_src[g-1]) begin n_fail++; $display("FAIL cont_last_src grant %0d: got %b want %b", g, a_last, exp_src[g-1]); end
                end
                if (since == 38) begin
                    n_checks++; if (cap !== exp_dat[g-1]) begin n_fail++; $display("FAIL cont_data grant %0d: got %h want %h", g, cap, exp_dat[g-1]); end
                end
            end
            if (a_r0 || a_r1) begin
                if (g < 3) begin
                    n_checks++; if (a_r1 !== exp_src[g]) begin n_fail++; $display("FAIL cont_src grant %0d: got %b want %b", g, a_r1, exp_src[g]); end
                    n_checks++; if (c != exp_cyc[g]) begin n_fail++; $display("FAIL cont_cycle grant %0d: got %0d want %0d", g, c, exp_cyc[g]); end
                end
                gcyc = c;
                g++;
            end
            tick();
            if (g >= 3) begin
                a_v0 = 1'b0;
                a_v1 = 1'b0;
            end
        end
        n_checks++; if (g != 3) begin n_fail++; $display("FAIL cont_grant_count: got %0d want 3", g); end
    endtask

    task automatic wait_idle(input string tag);
        int waited;
        waited = 0;
        while (a_busy === 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle_wait: got busy %b want 0", tag, a_busy); end
    endtask

    // s1 raised mid-frame must wait for the IDLE cycle after tx_done
    task automatic test_midframe_valid();
        int early;
        early = 0;
        wait_idle("midframe");
        a_d0 = 8'h3C;
        a_v0 = 1'b1;
        #1;
        n_checks++; if (a_r0 !== 1'b1) begin n_fail++; $display("FAIL mid_s0_ready: got %b want 1", a_r0); end
        tick();
        a_v0 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) begin
                a_d1 = 8'h5A;
                a_v1 = 1'b1;
                #1;
            end
            if (a_r1 === 1'b1) early++;
            if (k == 40) begin
                n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL mid_done: got %b want 1", a_done); end
            end
            tick();
        end
        n_checks++; if (early != 0) begin n_fail++; $display("FAIL mid_early_ready: got %0d cycles want 0", early); end
        n_checks++; if (a_r1 !== 1'b1)   begin n_fail++; $display("FAIL mid_s1_ready: got %b want 1", a_r1); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle_busy: got %b want 0", a_busy); end
        tick();
        a_v1 = 1'b0;
        n_checks++; if (a_last !== 1'b1) begin n_fail++; $display("FAIL mid_last_src: got %b want 1", a_last); end
        n_checks++; if (a_tx !== 1'b0)   begin n_fail++; $display("FAIL mid_start_tx: got %b want 0", a_tx); end
    endtask

    // Entered at frame cycle 1 of the 0x5A frame; reset during data bit 0
    task automatic test_reset_midframe();
        int bad_done;
        int bad_busy;
        logic [9:0] exp_seq;
        exp_seq = 10'b11_1000_0110;   // 0xC3 8N1
        bad_done = 0;
        bad_busy = 0;
        repeat (4) tick();
        n_checks++; if (a_tx !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pre_tx: got %b want 0", a_tx); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_checks++; if (a_tx !== 1'b1)   begin n_fail++; $display("FAIL rst_mid_tx: got %b want 1", a_tx); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", a_busy); end
        n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b want 0", a_done); end
        for (int k = 0; k < 50; k++) begin
            if (a_done === 1'b1) bad_done++;
            if (a_busy === 1'b1) bad_busy++;
            tick();
        end
        n_checks++; if (bad_done != 0) begin n_fail++; $display("FAIL rst_mid_late_done: got %0d pulses want 0", bad_done); end
        n_checks++; if (bad_busy != 0) begin n_fail++; $display("FAIL rst_mid_late_busy: got %0d cycles want 0", bad_busy); end
        a_d0 = 8'hC3;
        a_v0 = 1'b1;
        #1;
        n_checks++; if (a_r0 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_new_ready: got %b want 1", a_r0); end
        tick();
        a_v0 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            n_checks++; if (a_tx !== exp_seq[(k-1)/4]) begin n_fail++; $display("FAIL rst_mid_new_tx cyc %0d: got %b want %b", k, a_tx, exp_seq[(k-1)/4]); end
            n_checks++; if (a_done !== (k == 40)) begin n_fail++; $display("FAIL rst_mid_new_done cyc %0d: got %b want %b", k, a_done, (k == 40)); end
            tick();
        end
        n_checks++; if (a_last !== 1'b0) begin n_fail++; $display("FAIL rst_mid_new_last_src: got %b want 0", a_last); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_new_busy_end: got %b want 0", a_busy); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_stop2_5bit();
        test_contention();
        test_midframe_valid();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side scheduler for the UART TX path. It arbitrates round-robin between two byte requesters and frames the granted byte as start, data (LSB first), optional parity and stop bits. It then sequences the bits onto the serial line at a programmable baud rate. It sits between the TX data sources and the pad, and owns all bit timing for the shared line.

## Interface
- `CLK_DIV`, default 16: clock cycles per bit period; legal range is 2 or more.
- `DATA_BITS`, default 8: data bits per frame; legal range is 5–8.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `clk`, input, 1: the single clock. All logic is on its rising edge.
- `reset_n`, input, 1: reset, synchronous and active-low.
- `s0_valid`, input, 1: requester 0 has a byte.
- `s0_data`, input, 8: requester 0 byte. Only bits [DATA_BITS-1:0] are sent.
- `s0_ready`, output, 1: requester 0 byte is accepted this cycle.
- `s1_valid`, input, 1: requester 1 has a byte.
- `s1_data`, input, 8: requester 1 byte.
- `s1_ready`, output, 1: requester 1 byte is accepted this cycle.
- `tx`, output, 1: serial line. Idle level is 1.
- `busy`, output, 1: a frame is in progress (state is not IDLE).
- `tx_done`, output, 1: one-cycle pulse in the last cycle of the final stop bit.
- `last_src`, output, 1: source index of the most recently accepted byte.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Acceptance in IDLE:**
  - `sN_ready` = IDLE && `sN_valid` && (other valid low || round-robin priority favours N).
  - At most one ready is high per cycle. Ready never depends on anything except state, valids and the priority pointer.
  - Acceptance (valid && ready) latches the byte into the shift register, records the source in `last_src`, clears the bit counter and baud counter, and moves to START.
- **Round-robin:**
  - The priority pointer favours the port that was not granted last.
  - The pointer updates only on acceptance.
  - After reset the pointer favours port 0.
- **Bit periods:** each state holds for exactly `CLK_DIV` cycles, counted by a baud counter from 0 to `CLK_DIV`-1 that wraps to 0.
- **START:** `tx`=0.
- **DATA:**
  - `tx` = shift register bit 0. The register shifts right at each bit boundary.
  - After `DATA_BITS` periods, go to PARITY if `PARITY_EN`, else to STOP.
- **PARITY:** `tx` = XOR of the sent data bits, inverted when `PARITY_ODD`.
- **STOP:**
  - `tx`=1 for `STOP_BITS` periods.
  - `tx_done` pulses in the final cycle, then the block returns to IDLE.
- **Registered outputs:** `tx` is registered and glitch-free. It is driven from next-state logic so that it changes on the same edge the state changes.
- **Input sampling:** valids that arrive mid-frame are ignored until IDLE. Requesters must hold valid and data until ready.
- **Parameters:** checked with an elaboration-time error if `CLK_DIV`<2, if `DATA_BITS` is outside 5–8, or if `STOP_BITS` is not 1 or 2.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `tx_done`=0, `last_src`=0, `s0_ready`=`s1_ready`=0. State is IDLE and the priority pointer favours port 0.
- **Reset mid-frame:** returns to IDLE on the next edge. `tx` is 1 from that edge and the partial frame is dropped with no `tx_done`.
- **Latency:** the acceptance edge at cycle T drives `tx`=0 from cycle T+1.
- **Frame length:** `CLK_DIV`×(1+`DATA_BITS`+`PARITY_EN`+`STOP_BITS`) cycles from the first START cycle. `busy` is high over exactly that span.
- **`tx_done`:** high in the frame's last cycle. The next cycle is IDLE, so an acceptance can occur there at the earliest.
- **Back-to-back frames:** the minimum spacing is one IDLE cycle, i.e. frame length + 1 cycles between START edges.
- **Simultaneous valids:** both valid in the same IDLE cycle grants the favoured port only. The other port's ready stays 0 and it is served at the next IDLE.

## Test plan
- **Single frame:** reset, then `s0_valid` with data 0xA5, `CLK_DIV`=4, 8N1.
  - `tx` sequence per 4-cycle period: 0,1,0,1,0,0,1,0,1,1.
  - `busy` high for 40 cycles, `tx_done` in cycle 40, `last_src`=0.
- **Parity:** `PARITY_EN`=1, `PARITY_ODD`=0, data 0x07 gives parity bit 1. With `PARITY_ODD`=1 the parity bit is 0. Frame is 44 cycles at `CLK_DIV`=4.
- **Contention:** both valid from reset with data 0x11 and 0x22, held.
  - Frames alternate s0, s1, s0.
  - Each ready is high for exactly one cycle per grant.
  - `last_src` toggles.
- **Mid-frame valid:** `s1_valid` rises during DATA. `s1_ready` stays 0 until the IDLE cycle following `tx_done`, and is accepted there.
- **Reset mid-frame:** drop `reset_n` for 1 cycle in DATA.
  - `tx`=1, `busy`=0 next cycle, no `tx_done`.
  - A new s0 byte is then sent correctly.
- **Two stop bits and DATA_BITS=5:** data 0x1F sends 5 ones, then `tx` stays 1 for 2×`CLK_DIV` cycles before `tx_done`.
